// File: rtl/jogo_pkg.sv
// rtl/jogo_pkg.sv - state codes shared by the memory-game control unit
package jogo_pkg;

  localparam int ESTADO_CODE_W = 4;

  typedef enum logic [ESTADO_CODE_W-1:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMO        = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTO     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } estado_t;

endpackage

// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - Moore FSM sequencing the memory-game datapath
// Optional play-timeout path enabled by defining TIMEOUT_EN.
module unidade_controle
  import jogo_pkg::*;
#(
  parameter int ESTADO_W = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                igual,
  input  logic                fim_sequencia,
  input  logic                ultima_sequencia,
  input  logic                jogada_feita,
  input  logic                fim_timer,
  input  logic                fimE,
  output logic                zeraE,
  output logic                contaE,
  output logic                zeraL,
  output logic                contaL,
  output logic                zeraR,
  output logic                registraR,
  output logic                zera_timer,
  output logic                conta_timer,
  output logic                pronto,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic [ESTADO_W-1:0] db_estado
);

  estado_t state_q, state_d;

  // fimE is exported for debug only; fim_timer is dead when the timeout path is compiled out
  logic unused_inputs;
  assign unused_inputs = &{1'b0, fimE, fim_timer};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= INICIAL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = INICIAL;
    case (state_q)
      INICIAL:        state_d = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     state_d = INICIO_RODADA;
      INICIO_RODADA:  state_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // a play arriving together with the timeout still counts
        if (jogada_feita) state_d = REGISTRA;
`ifdef TIMEOUT_EN
        else if (fim_timer) state_d = FIM_TIMEOUT;
`endif
        else state_d = ESPERA_JOGADA;
      end
      REGISTRA:       state_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual)                                 state_d = FIM_ERRO;
        else if (fim_sequencia && ultima_sequencia) state_d = FIM_ACERTO;
        else if (fim_sequencia)                     state_d = PROXIMA_RODADA;
        else                                        state_d = PROXIMO;
      end
      PROXIMO:        state_d = ESPERA_JOGADA;
      PROXIMA_RODADA: state_d = INICIO_RODADA;
      FIM_ACERTO:     state_d = iniciar ? PREPARACAO : FIM_ACERTO;
      FIM_ERRO:       state_d = iniciar ? PREPARACAO : FIM_ERRO;
`ifdef TIMEOUT_EN
      FIM_TIMEOUT:    state_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
      default:        state_d = INICIAL;
    endcase
  end

  always_comb begin
    zeraE       = 1'b0;
    contaE      = 1'b0;
    zeraL       = 1'b0;
    contaL      = 1'b0;
    zeraR       = 1'b0;
    registraR   = 1'b0;
    zera_timer  = 1'b0;
    conta_timer = 1'b0;
    pronto      = 1'b0;
    acertou     = 1'b0;
    errou       = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      PREPARACAO: begin
        zeraE      = 1'b1;
        zeraL      = 1'b1;
        zeraR      = 1'b1;
        zera_timer = 1'b1;
      end
      INICIO_RODADA: begin
        zeraE      = 1'b1;
        zera_timer = 1'b1;
      end
`ifdef TIMEOUT_EN
      ESPERA_JOGADA: conta_timer = 1'b1;
`endif
      REGISTRA:       registraR  = 1'b1;
      COMPARACAO:     zera_timer = 1'b1;
      PROXIMO:        contaE     = 1'b1;
      PROXIMA_RODADA: contaL     = 1'b1;
      FIM_ACERTO: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
`ifdef TIMEOUT_EN
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        timeout = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign db_estado = ESTADO_W'(state_q);

endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - directed-vector bench for unidade_controle
module tb_unidade_controle;

  logic clock = 1'b0;
  logic reset, iniciar, igual, fim_sequencia, ultima_sequencia;
  logic jogada_feita, fim_timer, fimE;
  logic zeraE, contaE, zeraL, contaL, zeraR, registraR, zera_timer, conta_timer;
  logic pronto, acertou, errou, timeout;
  logic [4:0] db_estado;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  unidade_controle #(.ESTADO_W(5)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .igual(igual),
    .fim_sequencia(fim_sequencia), .ultima_sequencia(ultima_sequencia),
    .jogada_feita(jogada_feita), .fim_timer(fim_timer), .fimE(fimE),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .zera_timer(zera_timer),
    .conta_timer(conta_timer), .pronto(pronto), .acertou(acertou),
    .errou(errou), .timeout(timeout), .db_estado(db_estado)
  );

  // {zeraE,contaE,zeraL,contaL,zeraR,registraR,zera_timer,conta_timer,pronto,acertou,errou,timeout}
  function automatic logic [11:0] expected_outs(input logic [4:0] s);
    case (s)
      5'h1: return 12'b1010_1010_0000;
      5'h2: return 12'b1000_0010_0000;
`ifdef TIMEOUT_EN
      5'h3: return 12'b0000_0001_0000;
      5'hD: return 12'b0000_0000_1001;
`endif
      5'h4: return 12'b0000_0100_0000;
      5'h5: return 12'b0000_0010_0000;
      5'h6: return 12'b0100_0000_0000;
      5'h7: return 12'b0001_0000_0000;
      5'hA: return 12'b0000_0000_1100;
      5'hE: return 12'b0000_0000_1010;
      default: return 12'b0;
    endcase
  endfunction

  function automatic logic [11:0] outs();
    return {zeraE, contaE, zeraL, contaL, zeraR, registraR, zera_timer,
            conta_timer, pronto, acertou, errou, timeout};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one clock edge, then check state code and full output vector
  task automatic step(input string tag, input logic [4:0] exp_state);
    @(posedge clock);
    #1;
    check({tag, ".estado"}, 32'(db_estado), 32'(exp_state));
    check({tag, ".saidas"}, 32'(outs()), 32'(expected_outs(exp_state)));
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; igual = 1'b0; fim_sequencia = 1'b0;
    ultima_sequencia = 1'b0; jogada_feita = 1'b0; fim_timer = 1'b0; fimE = 1'b0;
    #3;
    check("reset.estado", 32'(db_estado), 32'h0);
    check("reset.saidas", 32'(outs()), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step("idle", 5'h0);

    // first round: single matching play ends the round
    iniciar = 1'b1;
    step("prep", 5'h1);
    iniciar = 1'b0;
    step("inicio", 5'h2);
    step("espera", 5'h3);
    jogada_feita = 1'b1; igual = 1'b1; fim_sequencia = 1'b1; ultima_sequencia = 1'b0;
    step("registra", 5'h4);
    jogada_feita = 1'b0;
    step("compara", 5'h5);
    step("prox_rodada", 5'h7);
    check("contaL_on", 32'(contaL), 32'h1);
    step("nova_rodada", 5'h2);
    check("contaL_off", 32'(contaL), 32'h0);
    step("espera2", 5'h3);

    // final round at limit 15: sixteen correct plays
    ultima_sequencia = 1'b1;
    for (int i = 0; i < 16; i++) begin
      jogada_feita = 1'b1;
      fim_sequencia = (i == 15);
      step("r15.reg", 5'h4);
      jogada_feita = 1'b0;
      step("r15.cmp", 5'h5);
      if (i < 15) begin
        step("r15.prox", 5'h6);
        step("r15.esp", 5'h3);
      end else begin
        step("r15.fim", 5'hA);
      end
    end
    check("acertou", 32'(acertou), 32'h1);
    check("pronto", 32'(pronto), 32'h1);
    fim_sequencia = 1'b0; ultima_sequencia = 1'b0;
    for (int i = 0; i < 3; i++) step("acerto.hold", 5'hA);
    iniciar = 1'b1;
    step("restart1", 5'h1);
    iniciar = 1'b0;
    step("inicio3", 5'h2);
    step("espera3", 5'h3);

    // wrong play
    jogada_feita = 1'b1; igual = 1'b0;
    step("erro.reg", 5'h4);
    jogada_feita = 1'b0;
    step("erro.cmp", 5'h5);
    step("erro.fim", 5'hE);
    check("errou", 32'(errou), 32'h1);
    check("erro.acertou", 32'(acertou), 32'h0);
    step("erro.hold", 5'hE);
    iniciar = 1'b1;
    step("restart2", 5'h1);
    iniciar = 1'b0;
    step("inicio4", 5'h2);
    step("espera4", 5'h3);

    // timer expiry with no play
    fim_timer = 1'b1;
`ifdef TIMEOUT_EN
    step("timeout.fim", 5'hD);
    check("timeout", 32'(timeout), 32'h1);
    fim_timer = 1'b0;
    iniciar = 1'b1;
    step("restart3", 5'h1);
    iniciar = 1'b0;
    step("inicio5", 5'h2);
    step("espera5", 5'h3);
`else
    step("timeout.ignorado", 5'h3);
    step("timeout.ignorado2", 5'h3);
    check("conta_timer", 32'(conta_timer), 32'h0);
    check("timeout_off", 32'(timeout), 32'h0);
    fim_timer = 1'b0;
`endif

    // play and timer in the same cycle: play wins
    jogada_feita = 1'b1; fim_timer = 1'b1; igual = 1'b1; fim_sequencia = 1'b0;
    step("simult.reg", 5'h4);
    jogada_feita = 1'b0; fim_timer = 1'b0;
    step("simult.cmp", 5'h5);
    step("simult.prox", 5'h6);

    // asynchronous reset in the middle of proximo
    #2;
    reset = 1'b0;
    #1;
    check("async.estado", 32'(db_estado), 32'h0);
    check("async.saidas", 32'(outs()), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    step("pos_reset", 5'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
